// File: rtl/mem_bus_master.sv
// mem_bus_master
// ---------------------------------------------------------------------------
// Bus initiator for a single-port synchronous RAM (we/address/datain/dataout,
// one-cycle registered read latency). A host issues burst commands; write
// bursts stream host words into RAM, read bursts return RAM words on a
// backpressured read stream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          burst command handshake (cmd_ready only in IDLE)
//   cmd_write, cmd_addr,     direction (1 = write), start address,
//   cmd_len                  length minus one (0 = 1 word, 255 = 256 words)
//   wr_valid/ready, wr_data  host write stream
//   rd_valid/ready, rd_data, read stream, rd_last marks the final word
//   rd_last
//   busy, done               busy outside IDLE, done pulses once per burst
//   mem_we, mem_address,     RAM request side
//   mem_datain, mem_dataout
//   dbg_state                current FSM state (IDLE=0, WRITE=1, RD_ISSUE=2,
//                            RD_CAPT=3, RD_HOLD=4, DONE=5)
//
// Handshake rule for all three streams: a transfer happens on a rising edge
// where valid and ready are both high. The producer keeps valid and payload
// stable until that edge; ready may change freely; the read stream here
// never withdraws rd_valid or changes rd_data/rd_last before the transfer.
// ---------------------------------------------------------------------------
module mem_bus_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;      // words remaining minus one
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? S_WRITE : S_RD_ISSUE;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        // The RAM write lands on the same edge as the host handshake.
        mem_we   = wr_valid;
        if (wr_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - ADDR_W'(1);
        end
      end
      // Address is presented here; the RAM returns data one cycle later.
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT: begin
        rd_data_d  = mem_dataout;
        rd_valid_d = 1'b1;
        rd_last_d  = (cnt_q == '0);
        state_d    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - ADDR_W'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Reset blocks every request-side strobe in the very cycle it is high.
    if (rst) begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      mem_we    = 1'b0;
    end
  end

  assign mem_address = addr_q;
  assign mem_datain  = wr_data;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;
  assign rd_data     = rd_data_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: behavioural RAM attached to the bus side,
// a flat reference memory plus expected-word queue as the model, and
// directed/randomised bursts driven from one initial block.
module tb_mem_bus_master;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_data;
  logic        busy, done, mem_we;
  logic [7:0]  mem_address;
  logic [15:0] mem_datain, mem_dataout;
  logic [2:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bus_master #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done),
    .mem_we(mem_we), .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .dbg_state(dbg_state)
  );

  // Single-port synchronous 256x16 RAM with registered read.
  logic [15:0] ram [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (mem_we) ram[mem_address] <= mem_datain;
    mem_dataout <= ram[mem_address];
  end

  // Edge monitors: RAM write strobes and done pulses.
  int we_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
    if (done === 1'b1)   done_cnt++;
  end

  // ---------------- scoreboard / model ----------------
  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  logic [15:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_wr_ready", wr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_ready_idle", cmd_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_dbg_state", dbg_state, 0);
  endtask

  // Returns at the negedge of the first cycle after the command is taken.
  task automatic send_cmd(input bit w, input logic [7:0] a, input logic [7:0] l);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1);
    check("cmd_ready_when_busy", cmd_ready, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 fixed 1,0,0,1,1,0,1 pattern, 2 random gaps.
  task automatic write_burst(input logic [7:0] a, input logic [7:0] len, input int gap_mode,
                             input bit use_base, input logic [15:0] base);
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [7:0]  cur = a;
    logic [15:0] d;
    bit v;
    int i = 0;
    int cyc = 0;
    int we0, done0;
    send_cmd(1'b1, a, len);
    we0 = we_cnt; done0 = done_cnt;
    while (i <= int'(len) && cyc < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc < 7) ? (pat[cyc] != 0) : 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = use_base ? base + 16'(i) : 16'($urandom);
      wr_valid = v; wr_data = d;
      // Commands offered mid-burst must be ignored.
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom);
      cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
      #1;
      check("wr_mem_we", mem_we, 32'(v));
      if (v) begin
        check("wr_addr", mem_address, cur);
        check("wr_datain", mem_datain, d);
        ref_mem[cur] = d;
        cur = cur + 8'd1;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0; cmd_valid = 1'b0;
    check("wr_done_pulse", done, 1);
    check("wr_count", we_cnt - we0, 32'(len) + 1);
    @(negedge clk);
    check("wr_done_low", done, 0);
    check("wr_cmd_ready_back", cmd_ready, 1);
    check("wr_done_count", done_cnt - done0, 1);
  endtask

  // stall < 0: random 0..2 stall cycles per word, otherwise fixed count.
  task automatic read_burst(input logic [7:0] a, input logic [7:0] len, input int stall);
    logic [7:0]  addr;
    logic [15:0] e;
    int lat, ns, done0;
    for (int k = 0; k <= int'(len); k++) exp_q.push_back(ref_mem[8'(int'(a) + k)]);
    send_cmd(1'b0, a, len);
    done0 = done_cnt;
    for (int i = 0; i <= int'(len); i++) begin
      addr = 8'(int'(a) + i);
      check("rd_issue_addr", mem_address, addr);
      check("rd_no_we", mem_we, 0);
      lat = 0;
      while (rd_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
      check("rd_latency", lat, 2);
      e = exp_q.pop_front();
      ns = (stall < 0) ? $urandom_range(0, 2) : stall;
      for (int s = 0; s < ns; s++) begin
        check("rd_hold_data", rd_data, e);
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_addr", mem_address, addr);
        @(negedge clk);
      end
      check("rd_data", rd_data, e);
      check("rd_last", rd_last, 32'(i == int'(len)));
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      check("rd_valid_drop", rd_valid, 0);
    end
    check("rd_done_pulse", done, 1);
    @(negedge clk);
    check("rd_done_low", done, 0);
    check("rd_cmd_ready_back", cmd_ready, 1);
    check("rd_done_count", done_cnt - done0, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0]  ra, rl;
    logic [15:0] d0;
    int done0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    apply_reset();

    // Basic write then read-back.
    write_burst(8'h10, 8'd3, 0, 1'b1, 16'hA001);
    read_burst(8'h10, 8'd3, 0);

    // Burst crossing the top of the address space.
    write_burst(8'hFE, 8'd3, 0, 1'b1, 16'h0001);
    read_burst(8'hFE, 8'd3, 0);

    // Read backpressure: 5 stall cycles on every word.
    read_burst(8'h10, 8'd3, 5);

    // Write with gaps in the host stream.
    write_burst(8'h80, 8'd3, 1, 1'b0, 16'h0000);
    read_burst(8'h80, 8'd3, -1);

    // Random bursts.
    for (int n = 0; n < 4; n++) begin
      ra = 8'($urandom); rl = 8'($urandom_range(0, 15));
      write_burst(ra, rl, 2, 1'b0, 16'h0000);
      ra = 8'($urandom); rl = 8'($urandom_range(0, 15));
      read_burst(ra, rl, -1);
    end

    // Full-memory burst: every location exactly once.
    ra = 8'($urandom);
    write_burst(ra, 8'd255, 2, 1'b0, 16'h0000);
    read_burst(ra, 8'd255, -1);

    // Reset in the middle of an 8-word write.
    send_cmd(1'b1, 8'h40, 8'd7);
    done0 = done_cnt;
    d0 = 16'($urandom);
    wr_valid = 1'b1; wr_data = d0;
    ref_mem[8'h40] = d0;
    @(negedge clk);
    wr_data = 16'($urandom);
    rst = 1'b1;
    #1;
    check("midrst_mem_we", mem_we, 0);
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mem_we_after", mem_we, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    check("midrst_no_done", done_cnt - done0, 0);
    read_burst(8'h40, 8'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Bus initiator that drives the single-port synchronous 256x16 RAM (clk, we, address, datain, dataout).
- Accepts burst commands (start address, length, direction) from a host over a valid/ready handshake.
- Write bursts: streams host words into RAM.
- Read bursts: issues addresses, captures RAM read data after its one-cycle registered latency, and returns words on a read stream with backpressure.

Parameters:
ADDR_W, 8, RAM address width; address arithmetic wraps modulo 2^ADDR_W.
DATA_W, 16, RAM data width.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous active-high reset.
cmd_valid  input  1  host command valid.
cmd_ready  output  1  high only in IDLE.
cmd_write  input  1  1 = write burst, 0 = read burst.
cmd_addr  input  ADDR_W  burst start address.
cmd_len  input  ADDR_W  burst length minus one (0 = 1 word, 255 = 256 words).
wr_valid  input  1  host write word valid.
wr_ready  output  1  master accepts write word.
wr_data  input  DATA_W  host write word.
rd_valid  output  1  read word valid.
rd_ready  input  1  host accepts read word.
rd_data  output  DATA_W  read word.
rd_last  output  1  qualifies final word of a read burst.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle pulse at burst completion.
mem_we  output  1  to RAM we.
mem_address  output  ADDR_W  to RAM address.
mem_datain  output  DATA_W  to RAM datain.
mem_dataout  input  DATA_W  from RAM dataout; valid the cycle after the address is presented.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset (rst) is synchronous and active-high.
  - rst forces state=IDLE and clears addr/count registers, rd_valid, rd_last, done, rd_data (to 0).
  - Combinational outputs while rst=1: mem_we=0, wr_ready=0, cmd_ready=0.
- Transfer registers: addr_q, cnt_q (words remaining minus one).
- States: IDLE, WRITE, RD_ISSUE, RD_CAPT, RD_HOLD, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: addr_q<=cmd_addr, cnt_q<=cmd_len; next state is WRITE if cmd_write=1, else RD_ISSUE.
- WRITE:
  - Combinational outputs: wr_ready=1, mem_we=wr_valid, mem_address=addr_q, mem_datain=wr_data.
  - On each wr_valid: addr_q<=addr_q+1 (wraps 255->0).
  - If cnt_q==0 go to DONE; otherwise cnt_q<=cnt_q-1.
  - wr_valid low stalls with no RAM write.
- RD_ISSUE:
  - mem_address=addr_q, mem_we=0.
  - Unconditionally next state RD_CAPT.
- RD_CAPT:
  - rd_data<=mem_dataout, rd_valid<=1, rd_last<=(cnt_q==0).
  - Next state RD_HOLD.
- RD_HOLD:
  - rd_valid/rd_data/rd_last are held stable until rd_ready=1.
  - On handshake: rd_valid<=0, rd_last<=0.
  - Then, if rd_last, go to DONE; otherwise addr_q<=addr_q+1 (wrapping), cnt_q<=cnt_q-1, next RD_ISSUE.
  - Read throughput: one word per 3 cycles minimum.
- DONE: done=1 for exactly one cycle, then IDLE. New commands are accepted only in IDLE.
- mem_address outside WRITE/RD_ISSUE: holds addr_q; mem_we=0 in every state but WRITE.
- Write latency: word in RAM at the same edge as the wr_valid&wr_ready handshake.
- Read latency: rd_valid rises 2 cycles after entering RD_ISSUE.
- Boundaries:
  - Burst crossing address 255 continues at 0.
  - cmd_len=255 transfers all 256 locations exactly once.
  - cmd_valid during busy is ignored (cmd_ready=0).
  - rst mid-burst aborts immediately; remaining words are discarded, no done pulse.
  - RAM contents written before the reset are retained.

Test Plan:
- Reset, then write burst addr=0x10 len=3, data 0xA001..0xA004 back-to-back -> mem_we high 4 cycles at addresses 0x10..0x13; done pulses once; cmd_ready returns.
- Read burst addr=0x10 len=3, rd_ready=1 -> rd_data 0xA001,0xA002,0xA003,0xA004; rd_last only on 0xA004; each rd_valid 2 cycles after its RD_ISSUE.
- Write addr=0xFE len=3 with data 1,2,3,4, then read the same range -> addresses 0xFE,0xFF,0x00,0x01 hold 1,2,3,4.
- Read with rd_ready low 5 cycles per word -> rd_data and rd_valid stable while stalled; no address advance; no word lost or duplicated.
- Write with wr_valid gaps (pattern 1,0,0,1,1,0,1) len=3 -> exactly 4 RAM writes to consecutive addresses; no write in gap cycles.
- Assert rst during word 2 of an 8-word write -> next cycle IDLE; mem_we=0, busy=0, no done pulse; new read command then executes normally.
